// File: rtl/alerm_set.sv
// Alarm-time setting block: a mode key walks an IDLE/HOUR/MIN/SEC edit FSM, an
// increment key bumps the selected field, and edit mode exits after an idle timeout.
module alerm_set #(
  parameter int data_width    = 18,
  parameter int second_cnt    = 52428800,
  parameter int counter_width = 26,
  parameter int timeout_sec   = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  // Key inputs are single-cycle pulses; each one is acted on at the edge that samples it.
  input  logic                  key_mode,
  input  logic                  key_inc,
  input  logic                  key_enable,
  output logic [data_width-1:0] alerm_data,
  output logic                  alerm_enable,
  output logic [1:0]            set_state,
  output logic                  blink
);

  localparam int IDLE_W = $clog2(timeout_sec + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOUR = 2'd1,
    ST_MIN  = 2'd2,
    ST_SEC  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [5:0]               hour_q, hour_d;
  logic [5:0]               min_q, min_d;
  logic [5:0]               sec_q, sec_d;
  logic                     en_q, en_d;
  logic [counter_width-1:0] presc_q, presc_d;
  logic [IDLE_W-1:0]        idle_cnt_q, idle_cnt_d;

  logic tick;
  logic any_key;
  logic timeout_hit;

  assign tick        = (presc_q == counter_width'(second_cnt - 1));
  assign any_key     = key_mode | key_inc | key_enable;
  assign timeout_hit = (state_q != ST_IDLE) && (idle_cnt_q == IDLE_W'(timeout_sec));

  always_comb begin
    state_d    = state_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    en_d       = en_q ^ key_enable;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    idle_cnt_d = idle_cnt_q;

    if (key_mode) begin
      // Mode wins over a simultaneous increment.
      case (state_q)
        ST_IDLE: state_d = ST_HOUR;
        ST_HOUR: state_d = ST_MIN;
        ST_MIN:  state_d = ST_SEC;
        default: state_d = ST_IDLE;
      endcase
    end else if (key_inc) begin
      case (state_q)
        ST_HOUR: hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
        ST_MIN:  min_d  = (min_q  == 6'd59) ? 6'd0 : min_q  + 6'd1;
        ST_SEC:  sec_d  = (sec_q  == 6'd59) ? 6'd0 : sec_q  + 6'd1;
        default: ;
      endcase
    end else if (!key_enable && timeout_hit) begin
      state_d = ST_IDLE;
    end

    if (any_key || (state_d != state_q) || (state_q == ST_IDLE)) begin
      idle_cnt_d = '0;
    end else if (tick && !timeout_hit) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      en_q       <= 1'b0;
      presc_q    <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      en_q       <= en_d;
      presc_q    <= presc_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // The comparator only sees the switch while not editing; the stored bit survives edits.
  assign alerm_data   = {hour_q, min_q, sec_q};
  assign alerm_enable = en_q && (state_q == ST_IDLE);
  assign set_state    = state_q;
  assign blink        = (state_q != ST_IDLE) && (presc_q < counter_width'(second_cnt / 2));

endmodule

// File: tb/tb_alerm_set.sv
// Directed bench for alerm_set with a short second (8 cycles) and 3-second timeout.
module tb_alerm_set;

  logic        clock;
  logic        reset;
  logic        key_mode;
  logic        key_inc;
  logic        key_enable;
  logic [17:0] alerm_data;
  logic        alerm_enable;
  logic [1:0]  set_state;
  logic        blink;

  int tests_run;
  int tests_failed;

  alerm_set #(
    .data_width   (18),
    .second_cnt   (8),
    .counter_width(26),
    .timeout_sec  (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_mode    (key_mode),
    .key_inc     (key_inc),
    .key_enable  (key_enable),
    .alerm_data  (alerm_data),
    .alerm_enable(alerm_enable),
    .set_state   (set_state),
    .blink       (blink)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given key pulses; outputs sampled 1 time unit after the edge.
  task automatic step(input logic m, input logic i, input logic e);
    key_mode   = m;
    key_inc    = i;
    key_enable = e;
    @(posedge clock);
    #1;
    key_mode   = 1'b0;
    key_inc    = 1'b0;
    key_enable = 1'b0;
  endtask

  // Leaves the bench at a negedge with reset released; the next posedge is edge 1.
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic logic [17:0] pack(input int h, input int m, input int s);
    logic [5:0] hh, mm, ss;
    hh = 6'(h);
    mm = 6'(m);
    ss = 6'(s);
    return {hh, mm, ss};
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    key_mode     = 1'b0;
    key_inc      = 1'b0;
    key_enable   = 1'b0;

    // Reset state
    do_reset();
    check("rst_state", set_state, 0);
    check("rst_data", alerm_data, 0);
    check("rst_enable", alerm_enable, 0);
    check("rst_blink", blink, 0);

    // Field wrap: hour 24 steps, minute and second 60 steps each, from 0
    step(1, 0, 0);
    check("enter_hour", set_state, 1);
    for (int i = 0; i < 24; i++) begin
      step(0, 1, 0);
      check("hour_wrap", alerm_data[17:12], (i + 1) % 24);
    end
    step(1, 0, 0);
    check("enter_min", set_state, 2);
    for (int i = 0; i < 60; i++) begin
      step(0, 1, 0);
      check("min_wrap", alerm_data[11:6], (i + 1) % 60);
    end
    step(1, 0, 0);
    check("enter_sec", set_state, 3);
    for (int i = 0; i < 60; i++) begin
      step(0, 1, 0);
      check("sec_wrap", alerm_data[5:0], (i + 1) % 60);
    end
    step(1, 0, 0);
    check("back_idle", set_state, 0);
    check("wrap_data", alerm_data, 0);

    // Basic edit sequence: hour 5, minute 2
    step(1, 0, 0);
    check("seq_s1", set_state, 1);
    repeat (5) step(0, 1, 0);
    step(1, 0, 0);
    check("seq_s2", set_state, 2);
    check("seq_hour", alerm_data, pack(5, 0, 0));
    repeat (2) step(0, 1, 0);
    step(1, 0, 0);
    check("seq_s3", set_state, 3);
    step(1, 0, 0);
    check("seq_s0", set_state, 0);
    check("seq_data", alerm_data, pack(5, 2, 0));

    // Increment in IDLE is ignored
    step(0, 1, 0);
    check("idle_inc", alerm_data, pack(5, 2, 0));

    // Enable switch and its masking during edit
    step(0, 0, 1);
    check("en_on", alerm_enable, 1);
    step(1, 0, 0);
    check("en_mask_state", set_state, 1);
    check("en_masked", alerm_enable, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("en_exit_state", set_state, 0);
    check("en_restored", alerm_enable, 1);

    // Mode and increment together in HOUR: mode wins
    step(1, 0, 0);
    step(1, 1, 0);
    check("both_state", set_state, 2);
    check("both_data", alerm_data, pack(5, 2, 0));

    // Enable toggles alongside a simultaneous increment, stays masked in MIN
    step(0, 1, 1);
    check("en_inc_data", alerm_data, pack(5, 3, 0));
    check("en_inc_masked", alerm_enable, 0);

    // Asynchronous reset mid-edit
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", set_state, 0);
    check("arst_data", alerm_data, 0);
    check("arst_enable", alerm_enable, 0);
    check("arst_blink", blink, 0);
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, 0);
    check("arst_rel_state", set_state, 0);
    check("arst_rel_data", alerm_data, 0);
    check("arst_rel_enable", alerm_enable, 0);

    // Timeout: edge 1 enters HOUR, edges 2-4 set hour 3, ticks at edges 8/16/24, exit at 25
    do_reset();
    step(1, 0, 0);
    check("to_enter", set_state, 1);
    check("to_blink1", blink, 1);
    repeat (3) step(0, 1, 0);
    check("to_hour", alerm_data, pack(3, 0, 0));
    check("to_blink4", blink, 0);
    for (int k = 5; k <= 24; k++) begin
      step(0, 0, 0);
      check("to_hold_state", set_state, 1);
      check("to_blink", blink, ((k % 8) < 4) ? 1 : 0);
    end
    step(0, 0, 0);
    check("to_exit_state", set_state, 0);
    check("to_exit_data", alerm_data, pack(3, 0, 0));
    check("to_exit_blink", blink, 0);
    repeat (3) step(0, 0, 0);
    check("to_after_blink", blink, 0);
    check("to_after_state", set_state, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
